// File: rtl/mem_ctrl_pkg.sv
// Shared types for the line-organised memory controller.
// Holds the controller FSM state encoding and an index-width helper.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  // Width of an index into n items; never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester pick: first req scanning upward from last_grant+1 with wrap.
// Combinational, zero latency; the pointer register lives in the caller.
module rr_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  input  logic          ena,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  always_comb begin
    int  idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last_grant) + i) % N;
      if (ena && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_ctrl_arb.sv
// Round-robin multi-accessor line memory: done arrives MEM_LATENCY+1 cycles after grant.
// Requesters hold their request until done; losers simply wait for a later arbitration.
module mem_ctrl_arb
  import mem_ctrl_pkg::*;
#(
  parameter int BITSIZE          = 32,
  parameter int N_WORDS_PER_ADDR = 4,
  parameter int MEM_SIZE         = 1024,
  parameter int N_ACCESSORS      = 4,
  parameter int MEM_LATENCY      = 2
) (
  input  logic                                          clk,
  input  logic                                          resetn_i,
  input  logic [N_ACCESSORS-1:0]                        acc_req_i,
  input  logic [N_ACCESSORS-1:0]                        acc_store_i,
  input  logic [32*N_ACCESSORS-1:0]                     acc_address_i,
  input  logic [N_WORDS_PER_ADDR*N_ACCESSORS-1:0]       acc_strb_i,
  input  logic [N_WORDS_PER_ADDR*BITSIZE*N_ACCESSORS-1:0] acc_data_i,
  output logic [N_WORDS_PER_ADDR*BITSIZE*N_ACCESSORS-1:0] acc_data_o,
  output logic [N_ACCESSORS-1:0]                        acc_done_o,
  output logic [N_ACCESSORS-1:0]                        acc_err_o,
  output logic                                          busy_o
);

  localparam int NW = N_WORDS_PER_ADDR;
  localparam int LW = NW * BITSIZE;
  localparam int AW = idx_w(MEM_SIZE);
  localparam int GW = idx_w(N_ACCESSORS);
  localparam int CW = idx_w(MEM_LATENCY + 1);

  state_t                            state;
  logic [GW-1:0]                     last_grant;
  logic [GW-1:0]                     grant_q;
  logic [GW-1:0]                     arb_idx;
  logic [N_ACCESSORS-1:0]            arb_grant;
  logic [31:0]                       addr_q;
  logic                              store_q;
  logic [NW-1:0]                     strb_q;
  logic [LW-1:0]                     wdata_q;
  logic [CW-1:0]                     cnt;
  logic [N_ACCESSORS-1:0][LW-1:0]    rdata_q;
  logic [N_ACCESSORS-1:0]            done_q;
  logic [N_ACCESSORS-1:0]            err_q;
  logic [LW-1:0]                     mem [MEM_SIZE];

  logic          in_range;
  logic          commit;
  logic [AW-1:0] line_idx;

  // Full 32-bit compare so aliased high addresses are still flagged.
  assign in_range = addr_q < 32'(MEM_SIZE);
  assign line_idx = addr_q[AW-1:0];
  assign commit   = (state == ACCESS) && (cnt == '0);

  rr_arbiter #(.N(N_ACCESSORS), .IW(GW)) u_arb (
    .req        (acc_req_i),
    .last_grant (last_grant),
    .ena        (state == IDLE),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  always_ff @(posedge clk) begin
    if (!resetn_i) begin
      state      <= IDLE;
      last_grant <= GW'(N_ACCESSORS - 1);
      grant_q    <= '0;
      addr_q     <= '0;
      store_q    <= 1'b0;
      strb_q     <= '0;
      wdata_q    <= '0;
      cnt        <= '0;
      rdata_q    <= '0;
      done_q     <= '0;
      err_q      <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state)
        IDLE: begin
          if (|arb_grant) begin
            grant_q    <= arb_idx;
            last_grant <= arb_idx;
            addr_q     <= acc_address_i[32*arb_idx +: 32];
            store_q    <= acc_store_i[arb_idx];
            strb_q     <= acc_strb_i[NW*arb_idx +: NW];
            wdata_q    <= acc_data_i[LW*arb_idx +: LW];
            cnt        <= CW'(MEM_LATENCY - 1);
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!store_q) rdata_q[grant_q] <= in_range ? mem[line_idx] : '0;
            done_q[grant_q] <= 1'b1;
            err_q[grant_q]  <= !in_range;
            state           <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Array is never reset; a reset landing on the commit cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (resetn_i && commit && store_q && in_range) begin
      for (int w = 0; w < NW; w++) begin
        if (strb_q[w]) mem[line_idx][w*BITSIZE +: BITSIZE] <= wdata_q[w*BITSIZE +: BITSIZE];
      end
    end
  end

  assign acc_data_o = rdata_q;
  assign acc_done_o = done_q;
  assign acc_err_o  = err_q;
  assign busy_o     = (state != IDLE);

endmodule

// File: tb/tb_mem_ctrl_arb.sv
// Directed bench for mem_ctrl_arb: default 4-accessor build plus a 1-accessor, latency-1 build.
module tb_mem_ctrl_arb;

  localparam int N  = 4;
  localparam int NW = 4;
  localparam int LW = 128;

  logic clk = 1'b0;
  logic resetn;

  logic [N-1:0]      req, store, done, err;
  logic [N*32-1:0]   addr;
  logic [N*NW-1:0]   strb;
  logic [N*LW-1:0]   wdata, rdata;
  logic              busy;

  logic              s_req, s_store, s_done, s_err, s_busy;
  logic [31:0]       s_addr;
  logic [NW-1:0]     s_strb;
  logic [LW-1:0]     s_wdata, s_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [LW-1:0] L5  = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  localparam logic [LW-1:0] LA  = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
  localparam logic [LW-1:0] LWX = {32'h5A5A0003, 32'h7A7A0002, 32'h8A8A0001, 32'h9A9A0000};
  localparam logic [LW-1:0] LP  = {32'hDDDD0003, 32'h7A7A0002, 32'hBBBB0001, 32'h9A9A0000};
  localparam logic [LW-1:0] L0  = {32'h0F0F0F0F, 32'h1E1E1E1E, 32'h2D2D2D2D, 32'h3C3C3C3C};
  localparam logic [LW-1:0] V1  = {32'hC0DE0009, 32'hC0DE0008, 32'hC0DE0007, 32'hC0DE0006};
  localparam logic [LW-1:0] V2  = {32'hBAD00009, 32'hBAD00008, 32'hBAD00007, 32'hBAD00006};

  always #5 clk = ~clk;

  mem_ctrl_arb u_dut (
    .clk           (clk),
    .resetn_i      (resetn),
    .acc_req_i     (req),
    .acc_store_i   (store),
    .acc_address_i (addr),
    .acc_strb_i    (strb),
    .acc_data_i    (wdata),
    .acc_data_o    (rdata),
    .acc_done_o    (done),
    .acc_err_o     (err),
    .busy_o        (busy)
  );

  mem_ctrl_arb #(.N_ACCESSORS(1), .MEM_LATENCY(1)) u_small (
    .clk           (clk),
    .resetn_i      (resetn),
    .acc_req_i     (s_req),
    .acc_store_i   (s_store),
    .acc_address_i (s_addr),
    .acc_strb_i    (s_strb),
    .acc_data_i    (s_wdata),
    .acc_data_o    (s_rdata),
    .acc_done_o    (s_done),
    .acc_err_o     (s_err),
    .busy_o        (s_busy)
  );

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction on accessor k; returns cycles from request to done and the err bit.
  task automatic txn(input int k, input logic st, input logic [31:0] a, input logic [3:0] sb,
                     input logic [LW-1:0] d, output int lat, output logic e);
    int w;
    w = 0;
    while (busy && w < 20) begin
      @(negedge clk);
      w++;
    end
    req[k] = 1'b1;
    store[k] = st;
    addr[32*k +: 32] = a;
    strb[NW*k +: NW] = sb;
    wdata[LW*k +: LW] = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done[k] && lat < 20);
    e = err[k];
    req[k] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic e;
    int g[$];
    int t[$];
    int multi;
    int first;

    resetn = 1'b0;
    req = '0; store = '0; addr = '0; strb = '0; wdata = '0;
    s_req = 1'b0; s_store = 1'b0; s_addr = '0; s_strb = '0; s_wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_err", 128'(err), 128'd0);
    for (int k = 0; k < N; k++) chk("reset_rdata", rdata[LW*k +: LW], '0);
    resetn = 1'b1;

    // Full-line write then read back on accessor 0.
    txn(0, 1'b1, 32'd5, 4'hF, L5, lat, e);
    chk("wr5_lat", 128'(lat), 128'd3);
    chk("wr5_err", 128'(e), 128'd0);
    txn(0, 1'b0, 32'd5, 4'h0, '0, lat, e);
    chk("rd5_lat", 128'(lat), 128'd3);
    chk("rd5_err", 128'(e), 128'd0);
    chk("rd5_data", rdata[0 +: LW], L5);

    // Partial write with strobes 0101.
    txn(0, 1'b1, 32'd7, 4'hF, LA, lat, e);
    txn(0, 1'b1, 32'd7, 4'b0101, LWX, lat, e);
    chk("wr_keeps_rdata", rdata[0 +: LW], L5);
    txn(0, 0, 32'd7, 4'h0, '0, lat, e);
    chk("rd7_partial", rdata[0 +: LW], LP);

    // Out-of-range addresses.
    txn(2, 1'b1, 32'd0, 4'hF, L0, lat, e);
    txn(0, 1'b0, 32'd1024, 4'h0, '0, lat, e);
    chk("oor1024_lat", 128'(lat), 128'd3);
    chk("oor1024_err", 128'(e), 128'd1);
    chk("oor1024_data", rdata[0 +: LW], '0);
    txn(1, 1'b0, 32'd5, 4'h0, '0, lat, e);
    chk("rd5_acc1", rdata[LW +: LW], L5);
    txn(1, 1'b0, 32'hFFFF_FFFF, 4'h0, '0, lat, e);
    chk("oormax_err", 128'(e), 128'd1);
    chk("oormax_data", rdata[LW +: LW], '0);
    txn(3, 1'b1, 32'd1024, 4'hF, L5, lat, e);
    chk("oor_wr_err", 128'(e), 128'd1);
    txn(3, 1'b0, 32'd0, 4'h0, '0, lat, e);
    chk("line0_intact", rdata[3*LW +: LW], L0);
    chk("line0_err", 128'(e), 128'd0);

    // Reset while a write to line 9 is in ACCESS with cnt=1.
    txn(0, 1'b1, 32'd9, 4'hF, V1, lat, e);
    @(negedge clk);
    req[0] = 1'b1; store[0] = 1'b1; addr[31:0] = 32'd9; strb[3:0] = 4'hF; wdata[LW-1:0] = V2;
    @(negedge clk);
    chk("mid_busy", 128'(busy), 128'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_rdata", rdata[0 +: LW], '0);
    req = '0;
    @(negedge clk);
    chk("rst_done2", 128'(done), 128'd0);
    resetn = 1'b1;
    txn(0, 1'b0, 32'd9, 4'h0, '0, lat, e);
    chk("line9_old", rdata[0 +: LW], V1);

    // All four accessors request continuously from reset.
    @(negedge clk);
    resetn = 1'b0;
    store = '0;
    for (int k = 0; k < N; k++) addr[32*k +: 32] = 32'd5;
    req = '1;
    @(negedge clk);
    resetn = 1'b1;
    multi = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (done != '0) begin
        if ($countones(done) > 1) multi++;
        for (int k = 0; k < N; k++) if (done[k]) g.push_back(k);
        t.push_back(n);
      end
    end
    req = '0;
    chk("rr_multi_done", 128'(multi), 128'd0);
    chk("rr_count", 128'(g.size()), 128'd5);
    for (int i = 0; i < 5; i++) chk("rr_order", 128'((i < g.size()) ? g[i] : -1), 128'(i % N));
    chk("rr_first_done", 128'((t.size() > 0) ? t[0] : -1), 128'd3);
    for (int i = 1; i < 5; i++)
      chk("rr_spacing", 128'((i < t.size()) ? t[i] - t[i-1] : -1), 128'd4);
    for (int k = 0; k < N; k++) chk("rr_rdata", rdata[LW*k +: LW], L5);

    // Latency-1, single-accessor build.
    @(negedge clk);
    s_req = 1'b1; s_store = 1'b1; s_addr = 32'd3; s_strb = 4'hF; s_wdata = LA;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!s_done && lat < 20);
    chk("small_wr_lat", 128'(lat), 128'd2);
    s_req = 1'b0;
    @(negedge clk);
    s_store = 1'b0;
    s_req = 1'b1;
    t.delete();
    first = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (s_done) begin
        t.push_back(n);
        first = 1;
        chk("small_rd_data", s_rdata, LA);
        chk("small_rd_err", 128'(s_err), 128'd0);
      end else if (first != 0) begin
        chk("small_hold", s_rdata, LA);
      end
    end
    s_req = 1'b0;
    chk("small_count", 128'(t.size()), 128'd4);
    chk("small_first", 128'((t.size() > 0) ? t[0] : -1), 128'd2);
    for (int i = 1; i < 4; i++)
      chk("small_spacing", 128'((i < t.size()) ? t[i] - t[i-1] : -1), 128'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
